div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit RV32M divide/remainder, restoring, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle instead of 32.
module div_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        op_stall,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] op_do
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_rem_sel;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_signed;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_res;
    logic        w_unused;

    assign w_unused = op[2];
    assign w_signed = ~op[0];
    assign w_neg1   = w_signed & op1[31];
    assign w_neg2   = w_signed & op2[31];
    assign w_abs1   = w_neg1 ? (~op1 + 32'd1) : op1;
    assign w_abs2   = w_neg2 ? (~op2 + 32'd1) : op2;

    // Partial remainder never exceeds 2*divisor-1, so 33 bits suffice
    assign w_sh     = {r_rem, r_quo[31]};
    assign w_diff   = w_sh - {1'b0, r_div};
    assign w_ge     = (w_sh >= {1'b0, r_div});
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};
    assign w_q_fix  = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_r_fix  = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;
    assign w_res    = r_rem_sel ? w_r_fix : w_q_fix;

    assign op_ready = (r_state == DONE) && !op_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            op_do     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (op_valid && !op_stall) begin
                        r_rem     <= '0;
                        r_quo     <= w_abs1;
                        r_div     <= w_abs2;
                        r_rem_sel <= op[1];
                        r_neg_q   <= (w_neg1 ^ w_neg2) && (op2 != '0);
                        r_neg_r   <= w_neg1;
`ifdef DIV_ZERO_FAST_EN
                        if (op2 == '0) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                            op_do   <= op[1] ? op1 : 32'hFFFF_FFFF;
                        end else
`endif
                        begin
                            r_state <= BUSY;
                            r_cnt   <= 6'd32;
                        end
                    end
                end
                BUSY: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= DONE;
                        op_do   <= w_res;
                    end
                end
                DONE: begin
                    if (op_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference of the RV32M divide/remainder rules.
module tb_div_unit;

    logic        clk;
    logic        rstn;
    logic        op_stall;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op_do;

    int checks;
    int failures;

    div_unit dut (
        .clk      (clk),
        .rstn     (rstn),
        .op_stall (op_stall),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .op1      (op1),
        .op2      (op2),
        .op_do    (op_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (f[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return f[1] ? r : q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input int sf, input int sl, input bit scr);
        logic [31:0] exp;
        int lat;
        int want;
        int cyc;
        bit got;
        exp = model(f, a, b);
        lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        want = lat;
        while (want >= sf && want < sf + sl) want++;
        @(negedge clk);
        op_valid = 1'b1;
        op       = f;
        op1      = a;
        op2      = b;
        op_stall = 1'b0;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            #1;
            cyc++;
            op_stall = (cyc >= sf && cyc < sf + sl);
            if (scr) begin
                op1 = $urandom;
                op2 = $urandom;
                op  = 3'($urandom);
            end
            #1;
            if (op_stall) begin
                chk({tag, "_stall_rdy"}, {31'd0, op_ready}, 32'd0);
                if (cyc >= lat) chk({tag, "_stall_do"}, op_do, exp);
            end
            if (op_ready) got = 1'b1;
            else @(posedge clk);
        end
        op_valid = 1'b0;
        op_stall = 1'b0;
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_lat"}, cyc, want);
        chk({tag, "_do"}, op_do, exp);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {31'd0, op_ready}, 32'd0);
        chk({tag, "_hold"}, op_do, exp);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int mode;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        op_stall = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        op1      = 32'd0;
        op2      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, op_ready}, 32'd0);
        chk("rst_do", op_do, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_op("divu", 3'b101, 32'd100, 32'd7, 0, 0, 1'b0);
        chk("divu_val", op_do, 32'd14);

        // Reset while the tenth step of divu 1000/3 is in flight
        @(negedge clk);
        op_valid = 1'b1;
        op       = 3'b101;
        op1      = 32'd1000;
        op2      = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        rstn     = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, op_ready}, 32'd0);
        chk("mid_rst_do", op_do, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_op("post_rst", 3'b101, 32'd9, 32'd4, 0, 0, 1'b0);
        chk("post_rst_val", op_do, 32'd2);

        run_op("remu", 3'b111, 32'd100, 32'd7, 0, 0, 1'b0);
        chk("remu_val", op_do, 32'd2);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        chk("div_neg_val", op_do, 32'hFFFF_FFFD);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1);
        chk("rem_neg_val", op_do, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("div_z", 3'b100, 32'hFFFF_FFF9, 32'd0, 0, 0, 1'b0);
        chk("div_z_val", op_do, 32'hFFFF_FFFF);
        run_op("rem_z", 3'b110, 32'hFFFF_FFF9, 32'd0, 0, 0, 1'b0);
        chk("rem_z_val", op_do, 32'hFFFF_FFF9);
        run_op("divu_z", 3'b101, 32'd12345, 32'd0, 0, 0, 1'b1);
        run_op("remu_z", 3'b111, 32'h8765_4321, 32'd0, 0, 0, 1'b0);
        run_op("stall", 3'b101, 32'd100, 32'd7, 31, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            f    = 3'($urandom);
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode == 2) b = 32'($urandom_range(1, 15));
            else if (mode == 3) b = -32'($urandom_range(1, 15));
            if (i % 3 == 0)
                run_op("rnd", f, a, b, $urandom_range(1, 40),
                       $urandom_range(0, 6), i[0]);
            else
                run_op("rnd", f, a, b, 0, 0, i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
